// File: rtl/id_ex_forward_stage_if.sv
// Signal bundle between the ID/EX stage and its surroundings: ID-side capture inputs,
// pipeline control, downstream writeback destinations and the registered EX-side outputs.
interface id_ex_forward_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
);
    logic               stall;
    logic               flush;

    logic               id_valid;
    logic [DATA_W-1:0]  id_pc4;
    logic [DATA_W-1:0]  id_rs_data;
    logic [DATA_W-1:0]  id_rt_data;
    logic [DATA_W-1:0]  id_imm;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic [REG_AW-1:0]  id_rd;
    logic               id_reg_write;
    logic               id_mem_to_reg;
    logic               id_mem_read;
    logic               id_mem_write;
    logic               id_alu_src;
    logic               id_reg_dst;
    logic [ALUOP_W-1:0] id_alu_op;

    logic               exmem_reg_write;
    logic [REG_AW-1:0]  exmem_rd;
    logic               memwb_reg_write;
    logic [REG_AW-1:0]  memwb_rd;

    logic               ex_valid;
    logic [DATA_W-1:0]  ex_pc4;
    logic [DATA_W-1:0]  ex_rs_data;
    logic [DATA_W-1:0]  ex_rt_data;
    logic [DATA_W-1:0]  ex_imm;
    logic [REG_AW-1:0]  ex_rs;
    logic [REG_AW-1:0]  ex_rt;
    logic [REG_AW-1:0]  ex_dest;
    logic               ex_reg_write;
    logic               ex_mem_to_reg;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic               ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic               load_use_hazard;

    // Pipeline side: drives ID and control, observes the stage.
    modport master (
        output stall, flush,
        output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
        output id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src,
        output id_reg_dst, id_alu_op,
        output exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
        input  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
        input  ex_alu_op, fwd_a, fwd_b, load_use_hazard
    );

    // Stage side.
    modport slave (
        input  stall, flush,
        input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
        input  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src,
        input  id_reg_dst, id_alu_op,
        input  exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest,
        output ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
        output ex_alu_op, fwd_a, fwd_b, load_use_hazard
    );
endinterface

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with stall/flush, plus the EX operand forwarding selects
// and the load-use hazard detector.
module id_ex_forward_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    id_ex_forward_stage_if.slave  bus
);

    localparam logic [1:0] SelRegFile = 2'b00;
    localparam logic [1:0] SelMemWb   = 2'b01;
    localparam logic [1:0] SelExMem   = 2'b10;

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  pc4;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  dest;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } idex_t;

    idex_t idex_q, idex_d;

    // Flush beats stall; an invalid ID slot still carries its fields but no side effects.
    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d = '0;
        end else if (!bus.stall) begin
            idex_d.valid      = bus.id_valid;
            idex_d.pc4        = bus.id_pc4;
            idex_d.rs_data    = bus.id_rs_data;
            idex_d.rt_data    = bus.id_rt_data;
            idex_d.imm        = bus.id_imm;
            idex_d.rs         = bus.id_rs;
            idex_d.rt         = bus.id_rt;
            idex_d.dest       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            idex_d.reg_write  = bus.id_valid & bus.id_reg_write;
            idex_d.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
            idex_d.mem_read   = bus.id_valid & bus.id_mem_read;
            idex_d.mem_write  = bus.id_valid & bus.id_mem_write;
            idex_d.alu_src    = bus.id_valid & bus.id_alu_src;
            idex_d.alu_op     = bus.id_valid ? bus.id_alu_op : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Newest producer wins; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              exmem_we,
        input logic [REG_AW-1:0] exmem_dst,
        input logic              memwb_we,
        input logic [REG_AW-1:0] memwb_dst
    );
        logic [1:0] sel;
        sel = SelRegFile;
        if (src != '0) begin
            if (exmem_we && (exmem_dst == src)) begin
                sel = SelExMem;
            end else if (memwb_we && (memwb_dst == src)) begin
                sel = SelMemWb;
            end
        end
        return sel;
    endfunction

    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       dest_hit;
    logic       hazard;

    always_comb begin
        fwd_a_sel = fwd_sel(idex_q.rs, bus.exmem_reg_write, bus.exmem_rd,
                            bus.memwb_reg_write, bus.memwb_rd);
        fwd_b_sel = fwd_sel(idex_q.rt, bus.exmem_reg_write, bus.exmem_rd,
                            bus.memwb_reg_write, bus.memwb_rd);
    end

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    always_comb begin
        dest_hit = (idex_q.dest == bus.id_rs) || (idex_q.dest == bus.id_rt);
        hazard   = idex_q.valid && idex_q.mem_read && (idex_q.dest != '0) && dest_hit;
    end

    assign bus.ex_valid        = idex_q.valid;
    assign bus.ex_pc4          = idex_q.pc4;
    assign bus.ex_rs_data      = idex_q.rs_data;
    assign bus.ex_rt_data      = idex_q.rt_data;
    assign bus.ex_imm          = idex_q.imm;
    assign bus.ex_rs           = idex_q.rs;
    assign bus.ex_rt           = idex_q.rt;
    assign bus.ex_dest         = idex_q.dest;
    assign bus.ex_reg_write    = idex_q.reg_write;
    assign bus.ex_mem_to_reg   = idex_q.mem_to_reg;
    assign bus.ex_mem_read     = idex_q.mem_read;
    assign bus.ex_mem_write    = idex_q.mem_write;
    assign bus.ex_alu_src      = idex_q.alu_src;
    assign bus.ex_alu_op       = idex_q.alu_op;
    assign bus.fwd_a           = fwd_a_sel;
    assign bus.fwd_b           = fwd_b_sel;
    assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Self-checking bench for id_ex_forward_stage: directed vector table, multi-cycle
// reset sequences, then randomized traffic against a behavioural model.
module tb_id_ex_forward_stage;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        asrc;
        logic        rdst;
        logic [3:0]  aop;
        logic        xw;
        logic [4:0]  xrd;
        logic        ww;
        logic [4:0]  wrd;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        asrc;
        logic [3:0]  aop;
    } exs_t;

    typedef struct {
        stim_t       stim;
        logic        e_valid;
        logic [31:0] e_rs_data;
        logic [4:0]  e_rs;
        logic [4:0]  e_dest;
        logic        e_rw;
        logic        e_mr;
        logic [1:0]  e_fa;
        logic [1:0]  e_fb;
        logic        e_hz;
    } vec_t;

    logic  clk;
    logic  reset;
    int    tests;
    int    fails;
    stim_t cur;
    exs_t  mdl;
    vec_t  vecs[10];

    id_ex_forward_stage_if #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4)) bus ();

    id_ex_forward_stage #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic stall, input logic flush, input logic valid,
                                 input logic [31:0] rs_data, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic rdst,
                                 input logic mr, input logic rw, input logic xw,
                                 input logic [4:0] xrd, input logic ww, input logic [4:0] wrd);
        stim_t s;
        s = '0;
        s.stall = stall;  s.flush = flush;  s.valid = valid;
        s.pc4 = 32'h0000_0104;  s.rs_data = rs_data;  s.rt_data = 32'hcafe_0000;
        s.imm = 32'h0000_0004;  s.rs = rs;  s.rt = rt;  s.rd = rd;  s.rdst = rdst;
        s.rw = rw;  s.m2r = mr;  s.mr = mr;  s.mw = 1'b0;  s.asrc = 1'b0;  s.aop = 4'h3;
        s.xw = xw;  s.xrd = xrd;  s.ww = ww;  s.wrd = wrd;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.stall = ($urandom_range(0, 5) == 0);
        s.flush = ($urandom_range(0, 7) == 0);
        s.valid = ($urandom_range(0, 3) != 0);
        s.pc4 = $urandom;  s.rs_data = $urandom;  s.rt_data = $urandom;  s.imm = $urandom;
        s.rs = 5'($urandom_range(0, 3));  s.rt = 5'($urandom_range(0, 3));
        s.rd = 5'($urandom_range(0, 3));
        s.rw = 1'($urandom_range(0, 1));  s.m2r = 1'($urandom_range(0, 1));
        s.mr = 1'($urandom_range(0, 1));  s.mw = 1'($urandom_range(0, 1));
        s.asrc = 1'($urandom_range(0, 1));  s.rdst = 1'($urandom_range(0, 1));
        s.aop = 4'($urandom_range(0, 15));
        s.xw = 1'($urandom_range(0, 1));  s.xrd = 5'($urandom_range(0, 3));
        s.ww = 1'($urandom_range(0, 1));  s.wrd = 5'($urandom_range(0, 3));
        return s;
    endfunction

    task automatic apply(input stim_t s);
        cur = s;
        bus.stall = s.stall;  bus.flush = s.flush;  bus.id_valid = s.valid;
        bus.id_pc4 = s.pc4;  bus.id_rs_data = s.rs_data;  bus.id_rt_data = s.rt_data;
        bus.id_imm = s.imm;  bus.id_rs = s.rs;  bus.id_rt = s.rt;  bus.id_rd = s.rd;
        bus.id_reg_write = s.rw;  bus.id_mem_to_reg = s.m2r;  bus.id_mem_read = s.mr;
        bus.id_mem_write = s.mw;  bus.id_alu_src = s.asrc;  bus.id_reg_dst = s.rdst;
        bus.id_alu_op = s.aop;
        bus.exmem_reg_write = s.xw;  bus.exmem_rd = s.xrd;
        bus.memwb_reg_write = s.ww;  bus.memwb_rd = s.wrd;
    endtask

    // Reference: what EX holds after an edge, from the stage's update rules.
    function automatic exs_t ref_next(input exs_t now, input stim_t s);
        exs_t n;
        if (s.flush) return '0;
        if (s.stall) return now;
        n.valid = s.valid;  n.pc4 = s.pc4;  n.rs_data = s.rs_data;  n.rt_data = s.rt_data;
        n.imm = s.imm;  n.rs = s.rs;  n.rt = s.rt;
        n.dest = s.rdst ? s.rd : s.rt;
        n.rw = s.valid && s.rw;  n.m2r = s.valid && s.m2r;  n.mr = s.valid && s.mr;
        n.mw = s.valid && s.mw;  n.asrc = s.valid && s.asrc;
        n.aop = s.valid ? s.aop : 4'h0;
        return n;
    endfunction

    // Producers listed newest first; the first live writer of src supplies the value.
    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input stim_t s);
        logic       we[2];
        logic [4:0] dst[2];
        logic [1:0] code[2];
        we = '{s.xw, s.ww};
        dst = '{s.xrd, s.wrd};
        code = '{2'b10, 2'b01};
        for (int i = 0; i < 2; i++) begin
            if (we[i] && src != 5'd0 && dst[i] == src) return code[i];
        end
        return 2'b00;
    endfunction

    function automatic logic ref_hz(input exs_t e, input stim_t s);
        return e.valid && e.mr && e.dest != 5'd0 && (e.dest == s.rs || e.dest == s.rt);
    endfunction

    task automatic step(input stim_t s);
        apply(s);
        @(posedge clk);
        if (!reset) mdl = ref_next(mdl, cur);
        #1;
    endtask

    task automatic check_all();
        chk("ex_valid", 32'(bus.ex_valid), 32'(mdl.valid));
        chk("ex_pc4", bus.ex_pc4, mdl.pc4);
        chk("ex_rs_data", bus.ex_rs_data, mdl.rs_data);
        chk("ex_rt_data", bus.ex_rt_data, mdl.rt_data);
        chk("ex_imm", bus.ex_imm, mdl.imm);
        chk("ex_rs", 32'(bus.ex_rs), 32'(mdl.rs));
        chk("ex_rt", 32'(bus.ex_rt), 32'(mdl.rt));
        chk("ex_dest", 32'(bus.ex_dest), 32'(mdl.dest));
        chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(mdl.rw));
        chk("ex_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(mdl.m2r));
        chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(mdl.mr));
        chk("ex_mem_write", 32'(bus.ex_mem_write), 32'(mdl.mw));
        chk("ex_alu_src", 32'(bus.ex_alu_src), 32'(mdl.asrc));
        chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(mdl.aop));
        chk("fwd_a", 32'(bus.fwd_a), 32'(ref_fwd(mdl.rs, cur)));
        chk("fwd_b", 32'(bus.fwd_b), 32'(ref_fwd(mdl.rt, cur)));
        chk("load_use_hazard", 32'(bus.load_use_hazard), 32'(ref_hz(mdl, cur)));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mdl = '0;

        // stall flush valid rs_data rs rt rd rdst mr rw | xw xrd ww wrd
        vecs[0] = '{mk(0,0,1,32'h12345678, 5, 3, 7,1,0,1, 1, 5,1, 5), 1,32'h12345678, 5, 7,1,0,2'b10,2'b00,0};
        vecs[1] = '{mk(1,0,1,32'hdeadbeef, 1, 2, 4,0,1,0, 0, 5,1, 5), 1,32'h12345678, 5, 7,1,0,2'b01,2'b00,0};
        vecs[2] = '{mk(1,0,1,32'hdeadbeef, 1, 2, 4,0,1,0, 1, 3,1, 3), 1,32'h12345678, 5, 7,1,0,2'b00,2'b10,0};
        vecs[3] = '{mk(1,0,1,32'hdeadbeef, 1, 2, 4,0,1,0, 0, 3,1, 3), 1,32'h12345678, 5, 7,1,0,2'b00,2'b01,0};
        vecs[4] = '{mk(1,1,1,32'hdeadbeef, 1, 2, 4,0,1,1, 1, 0,1, 0), 0,32'h00000000, 0, 0,0,0,2'b00,2'b00,0};
        vecs[5] = '{mk(0,0,1,32'ha5a5a5a5, 2, 9, 4,0,1,1, 0, 0,0, 0), 1,32'ha5a5a5a5, 2, 9,1,1,2'b00,2'b00,1};
        vecs[6] = '{mk(0,0,1,32'h00000000, 9, 0, 4,0,1,1, 1, 9,1, 0), 1,32'h00000000, 9, 0,1,1,2'b10,2'b00,0};
        vecs[7] = '{mk(0,0,0,32'h11111111, 6, 9, 4,0,1,1, 0, 0,0, 0), 0,32'h11111111, 6, 9,0,0,2'b00,2'b00,0};
        vecs[8] = '{mk(0,1,1,32'h22222222, 3, 3, 3,1,1,1, 1, 0,1, 0), 0,32'h00000000, 0, 0,0,0,2'b00,2'b00,0};
        vecs[9] = '{mk(0,0,1,32'hffffffff,31,31,31,1,0,1, 1,31,1,31), 1,32'hffffffff,31,31,1,0,2'b10,2'b10,0};

        // Reset with random inputs: everything reads zero before any edge.
        reset = 1'b1;
        apply(rnd_stim());
        #2;
        check_all();
        chk("reset ex_dest", 32'(bus.ex_dest), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].stim);
            chk("vec ex_valid", 32'(bus.ex_valid), 32'(vecs[i].e_valid));
            chk("vec ex_rs_data", bus.ex_rs_data, vecs[i].e_rs_data);
            chk("vec ex_rs", 32'(bus.ex_rs), 32'(vecs[i].e_rs));
            chk("vec ex_dest", 32'(bus.ex_dest), 32'(vecs[i].e_dest));
            chk("vec ex_reg_write", 32'(bus.ex_reg_write), 32'(vecs[i].e_rw));
            chk("vec ex_mem_read", 32'(bus.ex_mem_read), 32'(vecs[i].e_mr));
            chk("vec fwd_a", 32'(bus.fwd_a), 32'(vecs[i].e_fa));
            chk("vec fwd_b", 32'(bus.fwd_b), 32'(vecs[i].e_fb));
            chk("vec load_use_hazard", 32'(bus.load_use_hazard), 32'(vecs[i].e_hz));
        end

        // Reset arriving mid-stall clears at once; first capture after deassertion.
        step(mk(0,0,1,32'h5555aaaa,4,6,8,1,1,1,0,0,0,0));
        check_all();
        apply(mk(1,0,1,32'h77777777,1,1,1,1,1,1,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        mdl = '0;
        #1;
        chk("midstall ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("midstall ex_rs_data", bus.ex_rs_data, 32'd0);
        chk("midstall ex_dest", 32'(bus.ex_dest), 32'd0);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        step(mk(0,0,1,32'h0badf00d,7,8,9,1,0,1,0,0,0,0));
        chk("post-reset capture", bus.ex_rs_data, 32'h0badf00d);
        check_all();

        for (int n = 0; n < 400; n++) begin
            step(rnd_stim());
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
ID/EX pipeline register with hold (stall) and bubble (flush) control.
Also contains the EX-stage forwarding unit and load-use hazard detector.
Captures decoded operands and control from ID.
Drives the registered operands and the 2-bit select codes into the EX operand mux3x32to32 instances: select 00 = register file, 01 = MEM/WB writeback data, 10 = EX/MEM ALU result.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-index width
ALUOP_W, 4, ALU control code width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold all ID/EX registers
flush  in  1  load a bubble into ID/EX
id_valid  in  1  ID holds a real instruction
id_pc4  in  DATA_W  PC+4 of the ID instruction
id_rs_data  in  DATA_W  register file read port A
id_rt_data  in  DATA_W  register file read port B
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_AW each  source and destination indices
id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  in  1 each  decoded control
id_alu_op  in  ALUOP_W  ALU control
exmem_reg_write  in  1  EX/MEM will write the register file
exmem_rd  in  REG_AW  EX/MEM destination
memwb_reg_write  in  1  MEM/WB will write the register file
memwb_rd  in  REG_AW  MEM/WB destination
ex_valid  out  1  EX holds a real instruction
ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered copies of the ID inputs
ex_rs, ex_rt  out  REG_AW  registered source indices
ex_dest  out  REG_AW  registered destination: id_rd if id_reg_dst=1, else id_rt (selected at capture)
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered control
ex_alu_op  out  ALUOP_W  registered ALU control
fwd_a, fwd_b  out  2  operand mux selects for ex_rs and ex_rt
load_use_hazard  out  1  request an ID stall plus ID/EX bubble

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset). While reset=1, every registered output is 0, including ex_valid, all data fields, all control bits and ex_dest.
- Register update priority on each rising clk edge, reset deasserted:
  - flush=1 -> bubble: all control bits, ex_valid, indices and data fields go to 0. Flush wins over stall.
  - else stall=1 -> every register holds its value.
  - else capture from ID: ex_valid<=id_valid, and all fields and control bits are loaded.
  - If id_valid=0 at capture, control bits are forced to 0 (the bubble rule applies).
- Latency: ID inputs appear on the ex_* outputs one cycle after capture.
- Forwarding (combinational from registered ex_rs/ex_rt and the live EX/MEM and MEM/WB inputs); rule for fwd_a, and identically for fwd_b using ex_rt:
  - 10 if exmem_reg_write=1, exmem_rd!=0 and exmem_rd==ex_rs
  - else 01 if memwb_reg_write=1, memwb_rd!=0 and memwb_rd==ex_rs
  - else 00
  - EX/MEM has priority over MEM/WB (newest value wins).
  - Register 0 is never forwarded.
  - Select code 11 is never produced.
- load_use_hazard (combinational) = 1 when all of the following hold:
  - ex_valid=1
  - ex_mem_read=1
  - ex_dest!=0
  - ex_dest==id_rs, or ex_dest==id_rt
  - Otherwise 0.
  - The pipeline controller turns this into an IF/ID stall plus flush=1 here. The block does not self-flush.
- During a bubble, ex_rs=ex_rt=0, so fwd_a=fwd_b=00 and load_use_hazard=0.
- A reset asserted mid-stall clears the registers immediately. The first capture happens on the first edge after reset deasserts.
- No arithmetic is performed; widths pass through unchanged.

Test Plan:
- Reset: assert reset with all inputs at random values -> every ex_* output, fwd_a, fwd_b and load_use_hazard read 0 before any clock edge.
- Capture and hold:
  - Capture id_rs_data=0x12345678, id_reg_dst=1, id_rd=7, id_rt=3 -> next cycle ex_rs_data=0x12345678, ex_dest=7.
  - Then 3 cycles of stall=1 with new inputs -> the outputs stay unchanged.
- Flush priority: stall=1 and flush=1 together -> next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0, ex_rs=0.
- Forward priority: ex_rs=5, exmem_rd=5 and memwb_rd=5 with both write enables high -> fwd_a=10.
  - Drop exmem_reg_write -> fwd_a=01.
  - Set ex_rt=0 with memwb_rd=0 -> fwd_b=00.
- Load-use: ex_mem_read=1, ex_dest=9, id_rt=9 -> load_use_hazard=1.
  - Same with ex_dest=0 -> 0.
  - Same with ex_valid=0 -> 0.
